// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bank peripheral.
package spi_reg_pkg;

    // Frame length: one R/W bit, then the address, then the data word.
    function automatic int calc_frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Frame length for the default field widths (7-bit address, 8-bit data).
    localparam int FRAME_W = calc_frame_w(7, 8);

    // Value of the R/W bit that marks a write frame.
    localparam logic RW_WRITE = 1'b1;

    // Frame decoder states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_FULL = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage : spi_reg_pkg

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, plus single-cycle
// rise/fall pulses taken from the last stage.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchroniser and keep a delayed copy of the last stage.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule : spi_sync_edge

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: decodes R/W + address + data frames from the
// pins, writes the register file on a clean frame end, and shifts register
// contents back out on cipo for read frames.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS    = 5,
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       copi,
    input  logic                       sclk,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_LEN = calc_frame_w(ADDR_W, DATA_W);
    localparam int CMD_BITS  = 1 + ADDR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    // The receive shifter only needs to hold the command or the data word, never both.
    localparam int RX_W      = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;

    localparam logic [CNT_W-1:0]  CMD_CNT      = CMD_BITS[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  FRAME_CNT    = FRAME_LEN[CNT_W-1:0];
    localparam logic [ADDR_W:0]   NUM_REGS_EXT = NUM_REGS[ADDR_W:0];

    // Synchronised pins and edge pulses.
    logic w_copi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_copi_rise_unused;
    logic w_copi_fall_unused;
    logic w_sclk_level_unused;
    logic w_ncs_level_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (copi),
        .o_level (w_copi),
        .o_rise  (w_copi_rise_unused),
        .o_fall  (w_copi_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ncs),
        .o_level (w_ncs_level_unused),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    // Frame decoder state.
    state_e                           r_state;
    logic [CNT_W-1:0]                 r_bit_cnt;
    logic [RX_W-1:0]                  r_rx_shift;
    logic [DATA_W-1:0]                r_tx_shift;
    logic                             r_rw;
    logic [ADDR_W-1:0]                r_addr;
    logic                             r_addr_ok;
    logic                             r_rd_active;
    logic                             r_wr_strobe;
    logic [ADDR_W-1:0]                r_wr_addr;
    logic                             r_frame_err;
    logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;

    logic [RX_W-1:0]   w_rx_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_cmd_rw;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_addr_ok;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_commit;

    assign w_rx_next     = {r_rx_shift[RX_W-2:0], w_copi};
    assign w_cnt_next    = r_bit_cnt + 1'b1;
    assign w_cmd_rw      = w_rx_next[ADDR_W];
    assign w_cmd_addr    = w_rx_next[ADDR_W-1:0];
    assign w_cmd_addr_ok = ({1'b0, w_cmd_addr} < NUM_REGS_EXT);
    assign w_commit      = w_ncs_rise && (r_state == ST_FULL) && r_addr_ok && (r_rw == RW_WRITE);

    // Select the register addressed by the command just received.
    // NOTE: the default assignment before the loop keeps this purely combinational;
    // an unmatched address would otherwise infer a latch.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Frame decoder: ncs edges take priority over sclk edges, and ncs_rise over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_addr_ok   <= 1'b0;
            r_rd_active <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_ncs_rise) begin
                r_state     <= ST_IDLE;
                r_rd_active <= 1'b0;
                unique case (r_state)
                    ST_FULL: begin
                        if (w_commit) begin
                            r_wr_strobe <= 1'b1;
                            r_wr_addr   <= r_addr;
                        end else if (!r_addr_ok) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    ST_CMD, ST_DATA, ST_ERR: r_frame_err <= 1'b1;
                    default: ;
                endcase
            end else if (w_ncs_fall) begin
                // A fall outside IDLE means the previous frame never closed cleanly.
                if (r_state != ST_IDLE) begin
                    r_frame_err <= 1'b1;
                end
                r_state     <= ST_CMD;
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_rd_active <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_next;
                            r_bit_cnt  <= w_cnt_next;
                            if (w_cnt_next == CMD_CNT) begin
                                r_state   <= ST_DATA;
                                r_rw      <= w_cmd_rw;
                                r_addr    <= w_cmd_addr;
                                r_addr_ok <= w_cmd_addr_ok;
                                if ((w_cmd_rw != RW_WRITE) && w_cmd_addr_ok) begin
                                    r_tx_shift  <= w_rd_data;
                                    r_rd_active <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_next;
                            r_bit_cnt  <= w_cnt_next;
                            if (w_cnt_next == FRAME_CNT) begin
                                r_state <= ST_FULL;
                            end
                        end else if (w_sclk_fall && r_rd_active && (r_bit_cnt != CMD_CNT)) begin
                            // The fall right after the last address bit must not shift:
                            // the MSB has to stay on cipo until the first data-phase rise.
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_FULL: begin
                        if (w_sclk_rise) begin
                            r_state     <= ST_ERR;
                            r_rd_active <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file: updated only by a committed write.
    // NOTE: these registers drive outputs directly, so unlike a RAM they take the
    // asynchronous reset and must come up at a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= {NUM_REGS{RESET_VAL}};
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    r_regs[i] <= r_rx_shift[DATA_W-1:0];
                end
            end
        end
    end

    assign cipo      = r_rd_active ? r_tx_shift[DATA_W-1] : 1'b0;
    assign cipo_oe   = r_rd_active;
    assign regs_flat = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule : spi_reg_bank
